// File: rtl/i2c_byte_controller_pkg.sv
// Types shared by the I2C master blocks. This package holds the shift register
// load selects, the byte direction and the byte sequencer states.
package i2c_byte_controller_pkg;

  typedef enum logic [1:0] {
    SEL_ADDR    = 2'd0,
    SEL_DATA    = 2'd1,
    SEL_SUBADDR = 2'd2,
    SEL_NONE    = 2'd3
  } ShiftSelectType;

  typedef enum logic {
    DIR_TX = 1'b0,
    DIR_RX = 1'b1
  } DataDirection;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    ACK  = 2'd2
  } ByteCtrlState;

  localparam logic [3:0] LAST_BIT = 4'd7;

endpackage

// File: rtl/i2c_byte_controller.sv
// Byte sequencer for the I2C master shift register. It is paced by SCL edge strobes
// and covers 8 data bits plus the ACK slot.
//   state | meaning
//   IDLE  | waiting for byte_start; load/dir muxes pass inputs through
//   BITS  | shifting 8 data bits (TX drives MSB, RX samples on rise)
//   ACK   | ninth clock: sample slave ACK (TX) or drive ACK/NACK (RX)
module i2c_byte_controller
  import i2c_byte_controller_pkg::*;
(
  input  logic           clk,
  input  logic           n_rst,
  input  logic           byte_start,
  input  ShiftSelectType byte_select,
  input  DataDirection   byte_dir,
  input  logic           send_ack,
  input  logic           scl_rise,
  input  logic           scl_fall,
  input  logic           abort,
  input  logic           shift_out,
  input  logic           sda_in,
  output logic           shift_load,
  output logic           shift_strobe,
  output ShiftSelectType shift_input_select,
  output DataDirection   shift_direction,
  output logic           sda_out,
  output logic           busy,
  output logic           byte_done,
  output logic           ack_received,
  output logic           rx_valid
);

  ByteCtrlState   state, state_next;
  logic [3:0]     bit_cnt, bit_cnt_next;
  DataDirection   dir_q;
  ShiftSelectType sel_q;
  logic           send_ack_q;
  logic           rise_only, fall_only, accept, ack_slot_end;

  // Coincident edges carry no usable timing, so both are dropped.
  assign rise_only    = scl_rise & ~scl_fall;
  assign fall_only    = scl_fall & ~scl_rise;
  assign accept       = (state == IDLE) & byte_start & ~abort;
  assign ack_slot_end = (state == ACK) & fall_only & ~abort;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      dir_q        <= DIR_TX;
      sel_q        <= SEL_ADDR;
      send_ack_q   <= 1'b0;
      byte_done    <= 1'b0;
      rx_valid     <= 1'b0;
      ack_received <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      byte_done <= ack_slot_end;
      rx_valid  <= ack_slot_end & (dir_q == DIR_RX);
      if (accept) begin
        dir_q      <= byte_dir;
        sel_q      <= byte_select;
        send_ack_q <= send_ack;
      end
      if ((state == ACK) && (dir_q == DIR_TX) && rise_only && !abort)
        ack_received <= ~sda_in;
    end
  end

  always_comb begin
    state_next         = state;
    bit_cnt_next       = bit_cnt;
    shift_load         = 1'b0;
    shift_strobe       = 1'b0;
    shift_input_select = sel_q;
    shift_direction    = dir_q;
    sda_out            = 1'b1;
    busy               = 1'b0;
    case (state)
      IDLE: begin
        shift_input_select = byte_select;
        shift_direction    = byte_dir;
        if (accept) begin
          shift_load   = 1'b1;
          bit_cnt_next = '0;
          state_next   = BITS;
        end
      end
      BITS: begin
        busy = 1'b1;
        if (dir_q == DIR_TX) begin
          sda_out      = shift_out;
          shift_strobe = fall_only;
        end else begin
          shift_strobe = rise_only;
        end
        if (fall_only) begin
          bit_cnt_next = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) state_next = ACK;
        end
      end
      ACK: begin
        busy = 1'b1;
        if (dir_q == DIR_RX) sda_out = ~send_ack_q;
        if (fall_only) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next   = IDLE;
      shift_strobe = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_byte_controller.sv
// Directed bench for i2c_byte_controller. It models the shift register and an
// open-drain slave, and scoreboards the SDA bits and received bytes.
module tb_i2c_byte_controller;
  import i2c_byte_controller_pkg::*;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           byte_start = 1'b0;
  ShiftSelectType byte_select = SEL_ADDR;
  DataDirection   byte_dir = DIR_TX;
  logic           send_ack = 1'b0;
  logic           scl_rise = 1'b0;
  logic           scl_fall = 1'b0;
  logic           abort = 1'b0;
  logic           shift_out, sda_in;
  logic           shift_load, shift_strobe, sda_out, busy, byte_done, ack_received, rx_valid;
  ShiftSelectType shift_input_select;
  DataDirection   shift_direction;

  logic           slave_sda = 1'b1;
  logic [7:0]     sr = 8'h00;
  logic [7:0]     load_val [4];
  logic           exp_q [$];
  logic [7:0]     rx_q [$];
  int             errors = 0;
  int             checks = 0;
  logic           s;

  i2c_byte_controller dut (
    .clk(clk), .n_rst(n_rst), .byte_start(byte_start), .byte_select(byte_select),
    .byte_dir(byte_dir), .send_ack(send_ack), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .abort(abort), .shift_out(shift_out), .sda_in(sda_in), .shift_load(shift_load),
    .shift_strobe(shift_strobe), .shift_input_select(shift_input_select),
    .shift_direction(shift_direction), .sda_out(sda_out), .busy(busy),
    .byte_done(byte_done), .ack_received(ack_received), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  assign sda_in    = sda_out & slave_sda;
  assign shift_out = sr[7];

  always @(posedge clk) begin
    if (shift_load)        sr <= load_val[shift_input_select];
    else if (shift_strobe) sr <= {sr[6:0], sda_in};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r, input logic f, output logic strobe);
    scl_rise = r;
    scl_fall = f;
    #1;
    strobe = shift_strobe;
    tick();
    scl_rise = 1'b0;
    scl_fall = 1'b0;
  endtask

  task automatic start_byte(input DataDirection dir, input ShiftSelectType sel,
                            input logic sa, input logic [7:0] rx_byte);
    logic [7:0] tx_byte;
    byte_start  = 1'b1;
    byte_dir    = dir;
    byte_select = sel;
    send_ack    = sa;
    #1;
    chk("start_load", shift_load, 1'b1);
    chk("start_sel", shift_input_select, sel);
    tick();
    byte_start = 1'b0;
    chk("start_busy", busy, 1'b1);
    tx_byte = load_val[sel];
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back((dir == DIR_TX) ? tx_byte[i] : 1'b1);
    exp_q.push_back((dir == DIR_TX) ? 1'b1 : ~sa);
    if (dir == DIR_RX) rx_q.push_back(rx_byte);
  endtask

  function automatic logic pop_bit();
    if (exp_q.size() == 0) return 1'bx;
    return exp_q.pop_front();
  endfunction

  task automatic data_bit(input logic [7:0] rx_byte, input int i);
    logic st;
    slave_sda = (byte_dir == DIR_RX) ? rx_byte[7-i] : 1'b1;
    tick();
    chk("sda_bit", sda_out, pop_bit());
    pulse(1'b1, 1'b0, st);
    chk("rise_strobe", st, byte_dir == DIR_RX);
    tick();
    pulse(1'b0, 1'b1, st);
    chk("fall_strobe", st, byte_dir == DIR_TX);
  endtask

  task automatic ack_slot(input logic slave_drive);
    logic st;
    slave_sda = slave_drive;
    tick();
    chk("sda_ack", sda_out, pop_bit());
    pulse(1'b1, 1'b0, st);
    chk("ack_strobe", st, 1'b0);
    tick();
    slave_sda = 1'b1;
  endtask

  // Returns in the byte_done cycle so a caller can start the next byte there.
  task automatic finish_byte();
    logic st;
    logic [7:0] exp_rx;
    pulse(1'b0, 1'b1, st);
    chk("byte_done", byte_done, 1'b1);
    chk("rx_valid", rx_valid, byte_dir == DIR_RX);
    chk("busy_end", busy, 1'b0);
    if (byte_dir == DIR_RX) begin
      exp_rx = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      chk("rx_data", sr, exp_rx);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load"}, shift_load, 1'b0);
    chk({tag, "_strobe"}, shift_strobe, 1'b0);
    chk({tag, "_sda"}, sda_out, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, byte_done, 1'b0);
    chk({tag, "_ackrx"}, ack_received, 1'b0);
    chk({tag, "_rxv"}, rx_valid, 1'b0);
  endtask

  initial begin
    load_val[SEL_ADDR]    = 8'h5A;
    load_val[SEL_DATA]    = 8'hFF;
    load_val[SEL_SUBADDR] = 8'h00;
    load_val[SEL_NONE]    = 8'hA4;

    tick();
    tick();
    check_reset_outputs("rst");
    n_rst = 1'b1;
    tick();

    // TX address 0x5A, slave ACKs
    start_byte(DIR_TX, SEL_ADDR, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) data_bit(8'h00, i);
    ack_slot(1'b0);
    chk("tx1_ack", ack_received, 1'b1);
    finish_byte();
    tick();
    chk("tx1_done_low", byte_done, 1'b0);

    // RX 0x3C, master ACKs
    start_byte(DIR_RX, SEL_DATA, 1'b1, 8'h3C);
    chk("rx_dir", shift_direction, DIR_RX);
    for (int i = 0; i < 8; i++) data_bit(8'h3C, i);
    ack_slot(1'b1);
    chk("rx_ack_hold", ack_received, 1'b1);
    finish_byte();
    tick();
    chk("rx_valid_low", rx_valid, 1'b0);

    // TX 0xFF, slave NACKs, then back-to-back start in the byte_done cycle
    start_byte(DIR_TX, SEL_DATA, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) data_bit(8'h00, i);
    ack_slot(1'b1);
    chk("tx2_nack", ack_received, 1'b0);
    finish_byte();
    start_byte(DIR_TX, SEL_SUBADDR, 1'b0, 8'h00);

    // three bits, ignored start while busy, then abort
    for (int i = 0; i < 3; i++) data_bit(8'h00, i);
    byte_start  = 1'b1;
    byte_select = SEL_NONE;
    #1;
    chk("busy_start_load", shift_load, 1'b0);
    chk("busy_start_sel", shift_input_select, SEL_SUBADDR);
    tick();
    byte_start = 1'b0;
    chk("busy_start_busy", busy, 1'b1);
    chk("bits_sda", sda_out, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_sda", sda_out, 1'b1);
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1, s);
      chk("abort_no_done", byte_done, 1'b0);
    end

    // abort wins over a simultaneous start
    byte_start = 1'b1;
    abort      = 1'b1;
    #1;
    chk("abort_start_load", shift_load, 1'b0);
    tick();
    byte_start = 1'b0;
    abort      = 1'b0;
    chk("abort_start_busy", busy, 1'b0);

    // TX 0xA4 with coincident SCL edges mid-byte, then reset in the ACK slot
    start_byte(DIR_TX, SEL_NONE, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) data_bit(8'h00, i);
    pulse(1'b1, 1'b1, s);
    chk("both_edges_strobe", s, 1'b0);
    chk("both_edges_busy", busy, 1'b1);
    for (int i = 2; i < 8; i++) data_bit(8'h00, i);
    slave_sda = 1'b0;
    tick();
    chk("rst_sda_ack", sda_out, pop_bit());
    pulse(1'b1, 1'b0, s);
    chk("rst_ack_set", ack_received, 1'b1);
    n_rst    = 1'b0;
    scl_fall = 1'b1;
    tick();
    n_rst     = 1'b1;
    scl_fall  = 1'b0;
    slave_sda = 1'b1;
    check_reset_outputs("midrst");
    tick();
    chk("midrst_done_after", byte_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
